param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo_if.sv | 34 +++
 rtl/param_sync_fifo.sv | 109 ++++++++++
 tb/tb_param_sync_fifo.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/param_sync_fifo_if.sv
// Bus bundle between a FIFO user (master) and param_sync_fifo (slave).
// Signal names match the FIFO's port list so waveforms read the same either way.
interface param_sync_fifo_if #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a write is taken on an edge where i_wren is high and the FIFO is not full
  // (or a read is taken in the same cycle); a read is taken where i_rden is high and !o_empty.
  // Requests that are not taken only set the sticky error flags.
  logic             i_wren;
  logic [WIDTH-1:0] i_wrdata;
  logic             i_rden;
  logic             i_clr_err;
  logic [WIDTH-1:0] o_rddata;
  logic             o_full;
  logic             o_empty;
  logic             o_alm_full;
  logic             o_alm_empty;
  logic [CW-1:0]    o_count;
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_wren, i_wrdata, i_rden, i_clr_err,
    input  o_rddata, o_full, o_empty, o_alm_full, o_alm_empty, o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_wren, i_wrdata, i_rden, i_clr_err,
    output o_rddata, o_full, o_empty, o_alm_full, o_alm_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO of any depth >= 2 with registered status flags, sticky error
// flags, and a choice of registered-read or first-word-fall-through output.
module param_sync_fifo #(
  parameter int WIDTH        = 128,
  parameter int DEPTH        = 16,
  parameter int ALM_FULL_TH  = DEPTH - 2,
  parameter int ALM_EMPTY_TH = 2,
  parameter int FWFT         = 0
) (
  input  logic                clk,
  input  logic                reset,
  param_sync_fifo_if.slave    bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (!(ALM_EMPTY_TH >= 0 && ALM_EMPTY_TH < ALM_FULL_TH && ALM_FULL_TH <= DEPTH && DEPTH >= 2
        && WIDTH >= 1 && (FWFT == 0 || FWFT == 1))) begin : g_bad_params
    $fatal(1, "param_sync_fifo: illegal parameter set");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_alm_full;
  logic             r_alm_empty;
  logic             r_overflow;
  logic             r_underflow;
  logic [WIDTH-1:0] r_rddata;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [CW-1:0]    w_count_nxt;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;

  assign w_rd_acc     = bus.i_rden && !r_empty;
  assign w_wr_acc     = bus.i_wren && (!r_full || w_rd_acc);
  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)
      w_count_nxt = r_count + CW'(1);
    else if (w_rd_acc && !w_wr_acc)
      w_count_nxt = r_count - CW'(1);
  end

  // Storage is never reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc)
      r_mem[r_wr_ptr] <= bus.i_wrdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_alm_full  <= 1'b0;
      r_alm_empty <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rddata    <= '0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_acc) begin
        r_rd_ptr <= w_rd_ptr_nxt;
        // Non-blocking read of the old word gives read-before-write when full.
        r_rddata <= r_mem[r_rd_ptr];
      end
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == CW'(DEPTH));
      r_empty     <= (w_count_nxt == '0);
      r_alm_full  <= (w_count_nxt >= CW'(ALM_FULL_TH));
      r_alm_empty <= (w_count_nxt <= CW'(ALM_EMPTY_TH));
      // A new error event wins over a coincident clear.
      if (bus.i_wren && r_full && !w_rd_acc)
        r_overflow <= 1'b1;
      else if (bus.i_clr_err)
        r_overflow <= 1'b0;
      if (bus.i_rden && r_empty)
        r_underflow <= 1'b1;
      else if (bus.i_clr_err)
        r_underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.o_rddata = r_empty ? '0 : r_mem[r_rd_ptr];
  end else begin : g_reg_read
    assign bus.o_rddata = r_rddata;
  end

  assign bus.o_full      = r_full;
  assign bus.o_empty     = r_empty;
  assign bus.o_alm_full  = r_alm_full;
  assign bus.o_alm_empty = r_alm_empty;
  assign bus.o_count     = r_count;
  assign bus.o_overflow  = r_overflow;
  assign bus.o_underflow = r_underflow;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a DEPTH=16 registered-read instance and a DEPTH=5 FWFT
// instance, driven with directed vectors and checked against a queue model.
module tb_param_sync_fifo;
  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;

  param_sync_fifo_if #(.WIDTH(16), .DEPTH(16)) bus0 ();
  param_sync_fifo_if #(.WIDTH(8),  .DEPTH(5))  bus1 ();

  param_sync_fifo #(.WIDTH(16), .DEPTH(16), .FWFT(0)) dut0 (
    .clk(clk), .reset(rst0), .bus(bus0.slave)
  );
  param_sync_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(1)) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int          m_cnt [2];
  bit          m_ovf [2];
  bit          m_unf [2];
  bit          m_rd_done0 = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_status(input int s);
    int dep, afth, aeth;
    logic [31:0] cnt;
    logic full, empty, af, ae, ovf, unf;
    dep  = (s == 0) ? 16 : 5;
    afth = dep - 2;
    aeth = 2;
    if (s == 0) begin
      cnt = 32'(bus0.o_count); full = bus0.o_full; empty = bus0.o_empty;
      af = bus0.o_alm_full; ae = bus0.o_alm_empty; ovf = bus0.o_overflow; unf = bus0.o_underflow;
    end else begin
      cnt = 32'(bus1.o_count); full = bus1.o_full; empty = bus1.o_empty;
      af = bus1.o_alm_full; ae = bus1.o_alm_empty; ovf = bus1.o_overflow; unf = bus1.o_underflow;
    end
    check($sformatf("count%0d", s),     cnt, 32'(m_cnt[s]));
    check($sformatf("full%0d", s),      32'(full),  32'(m_cnt[s] == dep));
    check($sformatf("empty%0d", s),     32'(empty), 32'(m_cnt[s] == 0));
    check($sformatf("alm_full%0d", s),  32'(af),    32'(m_cnt[s] >= afth));
    check($sformatf("alm_empty%0d", s), 32'(ae),    32'(m_cnt[s] <= aeth));
    check($sformatf("overflow%0d", s),  32'(ovf),   32'(m_ovf[s]));
    check($sformatf("underflow%0d", s), 32'(unf),   32'(m_unf[s]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int s, input logic wr, input logic [15:0] d, input logic rd,
                       input logic clr);
    if (s == 0) begin
      bus0.i_wren = wr; bus0.i_wrdata = d; bus0.i_rden = rd; bus0.i_clr_err = clr;
    end else begin
      bus1.i_wren = wr; bus1.i_wrdata = d[7:0]; bus1.i_rden = rd; bus1.i_clr_err = clr;
    end
  endtask

  task automatic step(input int s, input logic wr, input logic [15:0] d, input logic rd,
                      input logic clr);
    int  dep;
    bit  full, ra, wa, was_empty;
    dep       = (s == 0) ? 16 : 5;
    full      = (m_cnt[s] == dep);
    was_empty = (m_cnt[s] == 0);
    ra        = rd && !was_empty;
    wa        = wr && (!full || ra);
    drive(s, wr, d, rd, clr);
    @(posedge clk);
    #1;
    drive(s, 1'b0, 16'h0, 1'b0, 1'b0);
    m_rd_done0 = (s == 0) && ra;
    if (s == 1 && ra) void'(exp_q1.pop_front());
    if (wa) begin
      if (s == 0) exp_q0.push_back(d);
      else        exp_q1.push_back({8'h00, d[7:0]});
    end
    m_cnt[s] = m_cnt[s] + int'(wa) - int'(ra);
    if (wr && full && !ra) m_ovf[s] = 1'b1;
    else if (clr)          m_ovf[s] = 1'b0;
    if (rd && was_empty)   m_unf[s] = 1'b1;
    else if (clr)          m_unf[s] = 1'b0;
    chk_status(s);
  endtask

  // Reset with requests active to show reset wins over them.
  task automatic do_reset(input int s);
    drive(s, 1'b1, 16'h5A5A, 1'b1, 1'b0);
    if (s == 0) rst0 = 1'b1; else rst1 = 1'b1;
    @(posedge clk);
    #1;
    if (s == 0) rst0 = 1'b0; else rst1 = 1'b0;
    drive(s, 1'b0, 16'h0, 1'b0, 1'b0);
    m_rd_done0 = 1'b0;
    m_cnt[s] = 0; m_ovf[s] = 1'b0; m_unf[s] = 1'b0;
    if (s == 0) exp_q0.delete(); else exp_q1.delete();
    chk_status(s);
    if (s == 0) check("rddata0_reset", 32'(bus0.o_rddata), 32'h0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (m_rd_done0) begin
      if (exp_q0.size() == 0) check("rd0_unexpected", 32'(bus0.o_rddata), 32'hFFFF_FFFF);
      else                    check("rd0_data", 32'(bus0.o_rddata), 32'(exp_q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst1 && m_cnt[1] != 0 && exp_q1.size() != 0)
      check("fwft1_data", 32'(bus1.o_rddata), 32'(exp_q1[0]));
  end

  // ---------------- stimulus ----------------
  initial begin
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_ovf[0] = 1'b0; m_ovf[1] = 1'b0; m_unf[0] = 1'b0; m_unf[1] = 1'b0;
    drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
    do_reset(0);
    do_reset(1);

    // Fill 0..15, status checked at every count (thresholds 2/3 and 13/14 included).
    for (int i = 0; i < 16; i++) step(0, 1'b1, 16'(i), 1'b0, 1'b0);
    step(0, 1'b1, 16'h0100, 1'b1, 1'b0);   // full: read+write both accepted
    step(0, 1'b1, 16'hDEAD, 1'b0, 1'b0);   // full, no read: dropped, overflow
    for (int i = 0; i < 16; i++) step(0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(0, 1'b1, 16'h0077, 1'b1, 1'b0);   // read while empty with write accepted
    check("rd0_hold", 32'(bus0.o_rddata), 32'h0100);
    step(0, 1'b0, 16'h0, 1'b0, 1'b1);      // clear both flags
    step(0, 1'b0, 16'h0, 1'b1, 1'b0);      // read 0x77
    step(0, 1'b0, 16'h0, 1'b1, 1'b1);      // underflow coincident with clear: stays set
    step(0, 1'b0, 16'h0, 1'b0, 1'b1);

    // Reset mid-stream at count 9.
    for (int i = 0; i < 9; i++) step(0, 1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
    do_reset(0);
    step(0, 1'b1, 16'h003C, 1'b0, 1'b0);
    step(0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(0, 1'b0, 16'h0, 1'b0, 1'b0);

    // FWFT instance: data visible without a read, then pointer wrap with order kept.
    step(1, 1'b1, 16'h00A5, 1'b0, 1'b0);
    check("fwft1_first", 32'(bus1.o_rddata), 32'hA5);
    step(1, 1'b1, 16'h0010, 1'b0, 1'b0);
    step(1, 1'b1, 16'h0011, 1'b0, 1'b0);
    step(1, 1'b1, 16'h0012, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1, 1'b1, 16'(16'h0013 + i), 1'b1, 1'b0);
    step(1, 1'b1, 16'h0017, 1'b0, 1'b0);   // reaches full
    step(1, 1'b1, 16'h0018, 1'b1, 1'b0);   // full read+write
    step(1, 1'b1, 16'h0019, 1'b0, 1'b0);   // overflow
    for (int i = 0; i < 5; i++) step(1, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1, 1'b0, 16'h0, 1'b1, 1'b1);      // underflow wins over clear
    step(1, 1'b0, 16'h0, 1'b0, 1'b1);

    @(negedge clk);
    check("q0_drained", 32'(exp_q0.size()), 32'h0);
    check("q1_drained", 32'(exp_q1.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
